// File: rtl/dispatch_request_fifo.sv
// dispatch_request_fifo
//  In-order request buffer between the warp scheduler and the ALU / LSU /
//  special-unit operand stages. Requests are stored in a DEPTH-entry ring,
//  then moved into a registered output stage that drives exactly one of the
//  three valid/ready channels, chosen by the request's one-hot unit flags.
//  count reports the ring occupancy; the output stage is not included.
//  Optional build macro: DISPATCH_FIFO_STATS_EN adds stall/high-water stats.
module dispatch_request_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned REQ_W = 103
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_tvalid_req,
  output logic                     s_tready_req,
  input  logic [REQ_W-1:0]         dispatch_request,
  output logic                     m_tvalid_alu,
  input  logic                     m_tready_alu,
  output logic                     m_tvalid_lsu,
  input  logic                     m_tready_lsu,
  output logic                     m_tvalid_special,
  input  logic                     m_tready_special,
  output logic [4:0]               m_warp_id,
  output logic [62:0]              m_instruction,
  output logic [31:0]              m_pred,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              err
`ifdef DISPATCH_FIFO_STATS_EN
  ,
  output logic [31:0]              stat_stall_cycles,
  output logic [$clog2(DEPTH):0]   stat_high_water
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] UNIT_ALU     = 3'b100;
  localparam logic [2:0] UNIT_LSU     = 3'b010;
  localparam logic [2:0] UNIT_SPECIAL = 3'b001;

  typedef struct packed {
    logic [4:0]  warp;
    logic [62:0] instr;
    logic [31:0] pred;
    logic [2:0]  unit;
  } req_t;

  logic [REQ_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [1:0]       err_q;

  req_t             head;
  logic             push_ok;
  logic             full;
  logic             out_busy;
  logic             accept;
  logic             load;
  logic             flags_ok;
  logic [CW-1:0]    count_next;

  // Head decode, handshake and occupancy bookkeeping
  always_comb begin
    head       = req_t'(mem[rd_ptr]);
    full       = (count == CW'(DEPTH));
    push_ok    = s_tvalid_req && !full;
    out_busy   = m_tvalid_alu || m_tvalid_lsu || m_tvalid_special;
    accept     = (m_tvalid_alu && m_tready_alu) ||
                 (m_tvalid_lsu && m_tready_lsu) ||
                 (m_tvalid_special && m_tready_special);
    load       = (count != '0) && (!out_busy || accept);
    flags_ok   = 1'b0;
    case (head.unit)
      UNIT_ALU, UNIT_LSU, UNIT_SPECIAL: flags_ok = 1'b1;
      default:                          flags_ok = 1'b0;
    endcase
    count_next = count + CW'(push_ok) - CW'(load);
  end

  // Ring storage; contents need no reset since pointers/count gate use
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= dispatch_request;
    end
  end

  // Pointers, occupancy and scheduler ready (ready leaves one slot of slack)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      s_tready_req <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (load)    rd_ptr <= rd_ptr + PW'(1);
      count        <= count_next;
      s_tready_req <= (count_next <= CW'(DEPTH - 2));
    end
  end

  // Output stage: load head on empty/accept; malformed flags are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid_alu     <= 1'b0;
      m_tvalid_lsu     <= 1'b0;
      m_tvalid_special <= 1'b0;
      m_warp_id        <= '0;
      m_instruction    <= '0;
      m_pred           <= '0;
    end else if (load) begin
      m_tvalid_alu     <= flags_ok && (head.unit == UNIT_ALU);
      m_tvalid_lsu     <= flags_ok && (head.unit == UNIT_LSU);
      m_tvalid_special <= flags_ok && (head.unit == UNIT_SPECIAL);
      if (flags_ok) begin
        m_warp_id     <= head.warp;
        m_instruction <= head.instr;
        m_pred        <= head.pred;
      end
    end else if (accept) begin
      m_tvalid_alu     <= 1'b0;
      m_tvalid_lsu     <= 1'b0;
      m_tvalid_special <= 1'b0;
    end
  end

  // Sticky error flags: overflow and non-one-hot unit flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      if (s_tvalid_req && full) err_q[0] <= 1'b1;
      if (load && !flags_ok)    err_q[1] <= 1'b1;
    end
  end

  assign err = {30'd0, err_q};

`ifdef DISPATCH_FIFO_STATS_EN
  logic stall;

  // A channel is stalled while its valid is up and its ready is low
  always_comb begin
    stall = (m_tvalid_alu && !m_tready_alu) ||
            (m_tvalid_lsu && !m_tready_lsu) ||
            (m_tvalid_special && !m_tready_special);
  end

  // Stall-cycle counter (wraps) and occupancy high-water mark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stall_cycles <= '0;
      stat_high_water   <= '0;
    end else begin
      if (stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (count_next > stat_high_water) stat_high_water <= count_next;
    end
  end
`endif

endmodule
